// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment vector type, blank code and the
// active-low {g,f,e,d,c,b,a} decode table for hex digits 0-F.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_display_scan_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment decode, shared by
// display blocks.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_HEX[value];
  end

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed common-anode 7-segment driver with frame-synchronous digit load.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS*4-1:0]   in,
  input  logic                  enable,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DW-1:0]       div_cnt;
  logic [IW-1:0]       idx;
  logic [DIGITS*4-1:0] shadow;
  logic                div_wrap;
  logic                frame_end;
  logic [3:0]          nibble;
  seg_t                digit_seg;
  logic [DIGITS-1:0]   an_next;
  logic                blank;

  assign div_wrap  = (div_cnt == DIV_LAST);
  assign frame_end = div_wrap && (idx == IDX_LAST);

  // Digit select as a compare-mux so non-power-of-two DIGITS never slices past shadow.
  always_comb begin
    nibble  = 4'h0;
    an_next = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nibble     = shadow[i*4 +: 4];
        an_next[i] = 1'b0;
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .value (nibble),
    .seg   (digit_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] upper_zero;

  // upper_zero[i] is set when nibbles i..DIGITS-1 are all zero.
  always_comb begin
    logic        acc;
    int unsigned d;
    acc        = 1'b1;
    upper_zero = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      d             = DIGITS - 1 - k;
      acc           = acc && (shadow[d*4 +: 4] == 4'h0);
      upper_zero[d] = acc;
    end
  end

  always_comb begin
    blank = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        blank = (i != 0) && upper_zero[i];
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      idx        <= '0;
      shadow     <= '0;
      an         <= '1;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
      if (frame_end) begin
        shadow <= in;
      end
      frame_done <= frame_end;
      an         <= enable ? an_next : '1;
      seg        <= (enable && !blank) ? digit_seg : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed self-checking bench for seg_display_scan with DIGITS=4, REFRESH_DIV=4.
module tb_seg_display_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_display_scan #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .enable     (enable),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hexseg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] digit_an(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    in     = 16'h1234;
    step();
    step();
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset: an=%b seg=%h fd=%b, want an=1111 seg=7f fd=0", an, seg, frame_done);
    end
    reset = 1'b0;
  endtask

  // One frame from a fresh reset: all digits show 0, frame_done on 16th edge.
  task automatic test_bringup();
    logic [3:0] ea;
    for (int j = 1; j <= 16; j++) begin
      step();
      ea = digit_an((j - 1) / 4);
      checks++;
      if (an !== ea || seg !== 7'h40 || frame_done !== (j == 16)) begin
        errors++;
        $display("FAIL bringup j=%0d: an=%b seg=%h fd=%b, want an=%b seg=40 fd=%b",
                 j, an, seg, frame_done, ea, (j == 16));
      end
    end
  endtask

  task automatic test_pattern(input logic [15:0] v, input int nframes);
    int         d;
    logic [3:0] ea;
    logic [6:0] es;
    for (int j = 1; j <= 16 * nframes; j++) begin
      step();
      d  = ((j - 1) % 16) / 4;
      ea = digit_an(d);
      es = hexseg(v[d*4 +: 4]);
      checks++;
      if (an !== ea || seg !== es || frame_done !== (j % 16 == 0)) begin
        errors++;
        $display("FAIL pattern %h j=%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                 v, j, an, seg, frame_done, ea, es, (j % 16 == 0));
      end
    end
  endtask

  // Frame displaying 1234 while in changes to 5678 after the 6th edge.
  task automatic test_midframe();
    int         d;
    logic [3:0] ea;
    logic [6:0] es;
    logic [15:0] shown;
    shown = 16'h1234;
    for (int j = 1; j <= 16; j++) begin
      step();
      if (j == 6) in = 16'h5678;
      d  = (j - 1) / 4;
      ea = digit_an(d);
      es = hexseg(shown[d*4 +: 4]);
      checks++;
      if (an !== ea || seg !== es || frame_done !== (j == 16)) begin
        errors++;
        $display("FAIL midframe j=%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                 j, an, seg, frame_done, ea, es, (j == 16));
      end
    end
  endtask

  // enable low for edges 8..17, straddling a frame boundary.
  task automatic test_enable();
    int         d;
    logic [3:0] ea;
    logic [6:0] es;
    logic [15:0] shown;
    shown = 16'hA3F0;
    for (int j = 1; j <= 32; j++) begin
      enable = !(j >= 8 && j <= 17);
      step();
      d = ((j - 1) % 16) / 4;
      if (enable) begin
        ea = digit_an(d);
        es = hexseg(shown[d*4 +: 4]);
      end else begin
        ea = 4'hF;
        es = 7'h7F;
      end
      checks++;
      if (an !== ea || seg !== es || frame_done !== (j % 16 == 0)) begin
        errors++;
        $display("FAIL enable j=%0d: an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
                 j, an, seg, frame_done, ea, es, (j % 16 == 0));
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    for (int j = 1; j <= 8; j++) step();
    reset = 1'b1;
    step();
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: an=%b seg=%h fd=%b, want an=1111 seg=7f fd=0", an, seg, frame_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_blank();
    logic [6:0] e42 [4];
    logic [6:0] e00 [4];
    logic [6:0] es;
    int         d;
`ifdef LEADING_ZERO_BLANK_EN
    e42 = '{7'h24, 7'h19, 7'h7F, 7'h7F};
    e00 = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
`else
    e42 = '{7'h24, 7'h19, 7'h40, 7'h40};
    e00 = '{7'h40, 7'h40, 7'h40, 7'h40};
`endif
    in = 16'h0042;
    test_pattern(16'hA3F0, 1);
    in = 16'h0000;
    for (int j = 1; j <= 32; j++) begin
      step();
      d  = ((j - 1) % 16) / 4;
      es = (j <= 16) ? e42[d] : e00[d];
      checks++;
      if (an !== digit_an(d) || seg !== es) begin
        errors++;
        $display("FAIL blank j=%0d: an=%b seg=%h, want an=%b seg=%h",
                 j, an, seg, digit_an(d), es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_midframe();
    in = 16'hA3F0;
    test_pattern(16'h5678, 1);
    test_pattern(16'hA3F0, 2);
    test_enable();
    test_reset_mid();
    test_bringup();
    test_pattern(16'hA3F0, 1);
    test_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
